// File: rtl/acc_feeder_pkg.sv
// rtl/acc_feeder_pkg.sv - shared state encoding and default constants for acc_feeder
package acc_feeder_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BURST_LEN  = 8;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_GAP_CYC    = 2;
   localparam int DEF_OPR_WAIT   = 8;
   localparam int DEF_RES_CNT    = 16;

   // Width of the shared per-state counter; wide enough for any of the phase lengths
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_SEND    = 3'd2,
      S_GAP     = 3'd3,
      S_WAIT    = 3'd4,
      S_CAPTURE = 3'd5,
      S_DRAIN   = 3'd6
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock input FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop balance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/acc_feeder.sv
// rtl/acc_feeder.sv - burst feeder and result collector for a streaming accelerator
module acc_feeder
   import acc_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_LEN  = DEF_BURST_LEN,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int GAP_CYC    = DEF_GAP_CYC,
   parameter int OPR_WAIT   = DEF_OPR_WAIT,
   parameter int RES_CNT    = DEF_RES_CNT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  func_sel_i,
   input  logic [3:0]            num_bursts,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] acc_data_o,
   output logic                  acc_data_valid,
   output logic                  func_sel,
   input  logic [DATA_WIDTH-1:0] acc_out,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int RW = (RES_CNT > 1) ? $clog2(RES_CNT) : 1;

   state_t                state;
   state_t                state_nx;
   logic [CNT_W-1:0]      cnt;
   logic [3:0]            bursts_tgt;
   logic [3:0]            bursts_sent;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic [CW-1:0]         fifo_count;
   logic                  burst_ready;
   logic                  send_last;
   logic [RW-1:0]         res_idx;
   logic [DATA_WIDTH-1:0] res_buf [RES_CNT];

   assign s_ready     = !fifo_full;
   assign fifo_push   = s_valid && !fifo_full;
   assign fifo_pop    = (state == S_SEND) && !fifo_empty;
   assign burst_ready = (fifo_count >= CW'(BURST_LEN));
   assign send_last   = (state == S_SEND) && (cnt == CNT_W'(BURST_LEN - 1));
   assign res_idx     = cnt[RW-1:0];

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (s_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and output decode; the FIFO head is shown combinationally while popping
   always_comb begin
      state_nx       = state;
      acc_data_valid = 1'b0;
      acc_data_o     = '0;
      m_valid        = 1'b0;
      m_data         = '0;
      done           = 1'b0;
      busy           = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            if (burst_ready) begin
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            acc_data_valid = 1'b1;
            acc_data_o     = fifo_dout;
            if (cnt == CNT_W'(BURST_LEN - 1)) begin
               state_nx = S_GAP;
            end
         end
         S_GAP: begin
            // When the next burst is already buffered, go straight to SEND so the
            // inter-burst gap is exactly GAP_CYC; otherwise wait for data in LOAD
            if (cnt == CNT_W'(GAP_CYC - 1)) begin
               if (bursts_sent == bursts_tgt) begin
                  state_nx = S_WAIT;
               end else if (burst_ready) begin
                  state_nx = S_SEND;
               end else begin
                  state_nx = S_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt == CNT_W'(OPR_WAIT - 1)) begin
               state_nx = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (cnt == CNT_W'(RES_CNT - 1)) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            m_valid = 1'b1;
            m_data  = res_buf[res_idx];
            if (m_ready && (cnt == CNT_W'(RES_CNT - 1))) begin
               done     = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Per-state cycle/word counter; restarts on every state change, holds while DRAIN stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state_nx != state) begin
         cnt <= '0;
      end else if (state == S_DRAIN) begin
         if (m_ready) begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if ((state != S_IDLE) && (state != S_LOAD)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Job parameters latched on start; burst tally advances on the last word of each burst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bursts_tgt  <= '0;
         bursts_sent <= '0;
         func_sel    <= 1'b0;
      end else if ((state == S_IDLE) && start) begin
         bursts_tgt  <= (num_bursts == 4'd0) ? 4'd1 : num_bursts;
         bursts_sent <= '0;
         func_sel    <= func_sel_i;
      end else if (send_last) begin
         bursts_sent <= bursts_sent + 4'd1;
      end
   end

   // Result capture in index order; buffer contents are meaningless until written
   always_ff @(posedge clk) begin
      if (state == S_CAPTURE) begin
         res_buf[res_idx] <= acc_out;
      end
   end

endmodule

// File: tb/tb_acc_feeder.sv
// tb/tb_acc_feeder.sv - scoreboard testbench for acc_feeder
`timescale 1ns/1ps
module tb_acc_feeder;

   localparam int DW  = 32;
   localparam int BL  = 8;
   localparam int GAP = 2;
   localparam int OW  = 8;
   localparam int RC  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          func_sel_i = 1'b0;
   logic [3:0]    num_bursts = 4'd0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] acc_data_o;
   logic          acc_data_valid;
   logic          func_sel;
   logic [DW-1:0] acc_out = '0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          busy;
   logic          done;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] push_q[$];
   logic [DW-1:0] exp_acc[$];
   logic [DW-1:0] exp_res[$];
   int            run_q[$];
   int            gap_q[$];
   int            run_len = 0;
   int            idle_len = 0;
   bit            mon_first = 1'b1;
   int            done_cnt = 0;
   bit            s_tog_mode = 1'b0;
   bit            s_phase = 1'b0;
   bit            m_tog_mode = 1'b0;
   logic          exp_func = 1'b0;
   int            since = 0;

   acc_feeder dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .func_sel_i     (func_sel_i),
      .num_bursts     (num_bursts),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .acc_data_o     (acc_data_o),
      .acc_data_valid (acc_data_valid),
      .func_sel       (func_sel),
      .acc_out        (acc_out),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (bound expired or unexpected event)", name);
   endtask

   // Host stream driver: presents push_q head, optionally only every other cycle
   initial forever begin
      @(negedge clk);
      if (rst && s_valid && s_ready) void'(push_q.pop_front());
      @(posedge clk);
      #1;
      s_phase = ~s_phase;
      if (push_q.size() > 0 && (!s_tog_mode || s_phase)) begin
         s_valid = 1'b1;
         s_data  = push_q[0];
      end else begin
         s_valid = 1'b0;
      end
   end

   // Host result backpressure
   initial forever begin
      @(posedge clk);
      #1;
      m_ready = m_tog_mode ? ~m_ready : 1'b1;
   end

   // Accelerator model: output is 100 + capture index, anchored to the last burst word
   initial forever begin
      @(negedge clk);
      if (acc_data_valid) since = 0;
      else since++;
      acc_out = DW'(100 + since - (GAP + OW + 1));
   end

   // Accelerator-side monitor: burst words, mode, burst lengths and gaps
   initial forever begin
      @(negedge clk);
      if (rst && acc_data_valid) begin
         if (exp_acc.size() == 0) fail_now("acc_unexpected_word");
         else begin
            check("acc_word", acc_data_o, exp_acc.pop_front());
            check("acc_func_sel", func_sel, exp_func);
         end
         if (run_len == 0 && !mon_first) gap_q.push_back(idle_len);
         mon_first = 1'b0;
         run_len++;
         idle_len = 0;
      end else begin
         if (run_len > 0) begin
            run_q.push_back(run_len);
            run_len = 0;
         end
         idle_len++;
      end
   end

   // Host-side result monitor: order, stall stability, done pulses
   initial begin
      bit            stalled;
      logic [DW-1:0] held;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (m_valid) begin
            if (stalled) check("m_data_stable", m_data, held);
            if (m_ready) begin
               if (exp_res.size() == 0) fail_now("m_unexpected_word");
               else check("m_data", m_data, exp_res.pop_front());
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = m_data;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic queue_words(input int first, input int n);
      for (int i = 0; i < n; i++) push_q.push_back(DW'(first + i));
   endtask

   task automatic wait_drained();
      int t = 0;
      while (push_q.size() > 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (push_q.size() > 0) fail_now("push_drain_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_full();
      int t = 0;
      while (s_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic run_job(input logic mode, input logic [3:0] nb, input int n_eff,
                          input int first, input bit rtog);
      int t;
      run_q.delete();
      gap_q.delete();
      mon_first  = 1'b1;
      done_cnt   = 0;
      idle_len   = 0;
      for (int i = 0; i < n_eff * BL; i++) exp_acc.push_back(DW'(first + i));
      for (int i = 0; i < RC; i++) exp_res.push_back(DW'(100 + i));
      exp_func   = mode;
      m_tog_mode = rtog;
      @(posedge clk); #2;
      start = 1'b1; func_sel_i = mode; num_bursts = nb;
      @(posedge clk); #2;
      start = 1'b0; func_sel_i = ~mode; num_bursts = 4'd5;
      @(posedge clk); #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      t = 0;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!done) fail_now("job_done_timeout");
      else check("busy_at_done", busy, 1);
      @(negedge clk);
      check("done_pulse_width", done, 0);
      check("busy_after_done", busy, 0);
      check("done_count", done_cnt, 1);
      check("acc_words_left", exp_acc.size(), 0);
      check("res_words_left", exp_res.size(), 0);
      check("burst_count", run_q.size(), n_eff);
      foreach (run_q[i]) check("burst_len", run_q[i], BL);
      check("gap_count", gap_q.size(), n_eff - 1);
      foreach (gap_q[i]) check("gap_len", gap_q[i], GAP);
      check("tail_idle_min", 32'(idle_len >= GAP + OW), 1);
      check("func_sel_hold_idle", func_sel, mode);
      exp_acc.delete();
      exp_res.delete();
      m_tog_mode = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_acc_valid", acc_data_valid, 0);
      check("rst_acc_data", acc_data_o, 0);
      check("rst_func_sel", func_sel, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s_ready", s_ready, 1);
      rst = 1'b1;

      // Single MM burst of 1..8 pre-loaded
      queue_words(1, 8);
      wait_drained();
      run_job(1'b0, 4'd1, 1, 1, 1'b0);

      // Three MM bursts, toggling s_valid, FIFO filled first
      s_tog_mode = 1'b1;
      queue_words(1, 24);
      wait_full();
      check("s_ready_full_tog", s_ready, 0);
      run_job(1'b0, 4'd3, 3, 1, 1'b0);
      s_tog_mode = 1'b0;

      // FIR, num_bursts = 0 treated as 1, m_ready toggling
      queue_words(32'hA0, 8);
      wait_drained();
      run_job(1'b1, 4'd0, 1, 32'hA0, 1'b1);

      // Full FIFO, simultaneous push/pop in SEND, pointer wrap
      queue_words(201, 16);
      wait_full();
      check("s_ready_full", s_ready, 0);
      queue_words(217, 8);
      fork
         run_job(1'b1, 4'd3, 3, 201, 1'b0);
         begin
            int w = 0;
            while (!acc_data_valid && w < 100) begin
               @(negedge clk);
               w++;
            end
            for (int i = 0; i < 7; i++) begin
               @(negedge clk);
               check("fifo_count_push_pop", 32'(dut.fifo_count), 15);
               check("s_ready_push_pop", s_ready, 1);
            end
         end
      join

      // Reset in SEND after word 4, then a fresh job
      queue_words(401, 8);
      wait_drained();
      exp_func = 1'b1;
      for (int i = 0; i < 4; i++) exp_acc.push_back(DW'(401 + i));
      @(posedge clk); #2;
      start = 1'b1; func_sel_i = 1'b1; num_bursts = 4'd1;
      @(posedge clk); #2;
      start = 1'b0;
      t = 0;
      while (!acc_data_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!acc_data_valid) fail_now("reset_test_send_timeout");
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_acc_valid", acc_data_valid, 0);
      check("mid_rst_acc_data", acc_data_o, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_func_sel", func_sel, 0);
      check("mid_rst_s_ready", s_ready, 1);
      check("mid_rst_words_seen", exp_acc.size(), 0);
      exp_acc.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      queue_words(501, 16);
      wait_drained();
      run_job(1'b0, 4'd2, 2, 501, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acc_feeder.md
ACC_FEEDER -- requirements
Module: acc_feeder

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of all data words.
REQ-002 Parameter: BURST_LEN, 8, words per input burst to the accelerator.
REQ-003 Parameter: FIFO_DEPTH, 16, input FIFO entries (power of 2, >= BURST_LEN).
REQ-004 Parameter: GAP_CYC, 2, idle cycles forced between bursts.
REQ-005 Parameter: OPR_WAIT, 8, cycles waited after the last burst before capture.
REQ-006 Parameter: RES_CNT, 16, result words captured per job.
REQ-007 Port: clk  in  1  single clock; all logic is on its rising edge.
REQ-008 Port: rst  in  1  reset, asynchronous, active-low.
REQ-009 Port: start / func_sel_i / num_bursts  in  1/1/4  job start pulse / mode (0 = MM, 1 = FIR) / burst count 1..15.
REQ-010 Port: s_data / s_valid / s_ready  in/in/out  DATA_WIDTH/1/1  host word stream into the input FIFO.
REQ-011 Port: acc_data_o / acc_data_valid / func_sel  out/out/out  DATA_WIDTH/1/1  drive to the accelerator.
REQ-012 Port: acc_out  in  DATA_WIDTH  accelerator result, one word per cycle during capture.
REQ-013 Port: m_data / m_valid / m_ready  out/out/in  DATA_WIDTH/1/1  result stream to the host.
REQ-014 Port: busy / done  out  1/1  job in progress / one-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, LOAD, SEND, GAP, WAIT, CAPTURE, DRAIN.
REQ-016 IDLE -> LOAD on start; num_bursts and func_sel_i are latched; start is ignored when not in IDLE.
REQ-017 LOAD -> SEND once the FIFO holds >= BURST_LEN words.
REQ-018 SEND: pops one word per cycle, acc_data_valid = 1 for exactly BURST_LEN consecutive cycles, acc_data_o = popped word in the same cycle.
REQ-019 SEND -> GAP after BURST_LEN words; GAP holds acc_data_valid = 0 for GAP_CYC cycles.
REQ-020 GAP -> LOAD while bursts remain, else -> WAIT.
REQ-021 WAIT counts OPR_WAIT cycles with acc_data_valid = 0, then -> CAPTURE.
REQ-022 CAPTURE samples acc_out into the result buffer on RES_CNT consecutive cycles, in index order 0..RES_CNT-1, then -> DRAIN.
REQ-023 DRAIN presents buffer words in order; a word is transferred when m_valid && m_ready; m_data stays stable while m_valid && !m_ready.
REQ-024 After the last result transfer: done = 1 for one cycle, -> IDLE.
REQ-025 func_sel holds the latched mode from LOAD entry until IDLE; in IDLE it holds its last value.
REQ-026 s_ready = !fifo_full; a push and a pop in the same cycle are both accepted, and the count is unchanged.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; pushes are accepted in any state, including IDLE.
REQ-028 busy = 1 in every state except IDLE.
REQ-029 num_bursts = 0 at start is treated as 1.

Reset
REQ-030 Asserting rst at any time, including mid-job, returns the block to IDLE immediately.
REQ-031 Reset values: FIFO empty, acc_data_valid = 0, acc_data_o = 0, func_sel = 0, m_valid = 0, m_data = 0, busy = 0, done = 0, s_ready = 1, all counters = 0.
REQ-032 Result buffer contents are not reset; they are don't-care until captured.

Structure
REQ-033 A shared package holds the FSM state encoding and the default parameter constants.
REQ-034 The input FIFO is one sub-module, sync_fifo, with ports push, pop, din, dout, full, empty and count.

Verification
REQ-035 Pre-load 8 words 1..8, start with MM mode and num_bursts = 1 -> acc_data_valid high for 8 cycles carrying 1..8, func_sel = 0, then low for >= GAP_CYC + OPR_WAIT cycles.
REQ-036 MM, num_bursts = 3, words 1..24 streamed with s_valid toggling -> three 8-cycle bursts, each separated by exactly 2 idle cycles, order preserved.
REQ-037 acc_out = 100 + cycle index during CAPTURE, m_ready tied 1 -> m_data reads 100..115, done pulses once, busy falls the next cycle.
REQ-038 m_ready toggled 1/0 during DRAIN -> no word is lost or duplicated, and m_data is stable while stalled.
REQ-039 FIFO filled to 16 -> s_ready = 0; a simultaneous push and pop in SEND -> count unchanged; pointers wrap correctly.
REQ-040 rst asserted in SEND after word 4 -> acc_data_valid = 0 immediately and state = IDLE; a new job afterwards completes normally.
